// File: rtl/arinc429_pkg.sv
// rtl/arinc429_pkg.sv - shared types, constants and round-robin pick for the ARINC 429 tx scheduler
package arinc429_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    SEND,
    GAP
  } sched_state_t;

  localparam int ARINC_WORD_W = 32;
  localparam int DEF_BIT_CLKS = 1000;
  localparam int DEF_GAP_BITS = 4;
  localparam int MAX_REQ      = 8;

  // First set bit at or after last+1, wrapping mod n; returns last when nothing is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] pend,
                                         input logic [2:0]         last,
                                         input int                 n);
    logic [2:0] pick;
    int         idx;
    pick = last;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        idx = int'(last) + i;
        if (idx >= n) idx = idx - n;
        if (pend[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arinc429_req_edge.sv
// rtl/arinc429_req_edge.sv - N-bit rising-edge detector
module arinc429_req_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);

  logic [N-1:0] din_d;

  always_ff @(posedge clk) begin
    if (rst) din_d <= '0;
    else     din_d <= din;
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/arinc429_tx_sched.sv
// rtl/arinc429_tx_sched.sv - round-robin ARINC 429 transmit scheduler with inter-word gap
module arinc429_tx_sched
  import arinc429_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int BIT_CLKS = DEF_BIT_CLKS,
  parameter int GAP_BITS = DEF_GAP_BITS,
  parameter int BUSY_TMO = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_REQ-1:0]              req,
  input  logic [ARINC_WORD_W*N_REQ-1:0] word_in,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [ARINC_WORD_W-1:0]       tx_word,
  output logic [N_REQ-1:0]              grant,
  output logic [N_REQ-1:0]              ack,
  output logic [N_REQ-1:0]              pending,
  output logic                          err_tmo
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(BUSY_TMO + 1);
  localparam int GAP_W = 19;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_BITS * BIT_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  sched_state_t            state, state_nxt;
  logic [N_REQ-1:0]        rise;
  logic [MAX_REQ-1:0]      pend_ext;
  logic [2:0]              last, pick;
  logic [IDX_W-1:0]        sel;
  logic [ARINC_WORD_W-1:0] words [N_REQ];
  logic [TMO_W-1:0]        tmo_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    do_pick, do_issue, tmo_hit, gap_done, gap_load;

  arinc429_req_edge #(.N(N_REQ)) u_req_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (req),
    .rise (rise)
  );

  always_comb begin
    pend_ext = '0;
    pend_ext[N_REQ-1:0] = pending;
    pick = rr_pick(pend_ext, last, N_REQ);
    sel  = pick[IDX_W-1:0];
    for (int i = 0; i < N_REQ; i++) words[i] = word_in[i*ARINC_WORD_W +: ARINC_WORD_W];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_pick   = 1'b0;
    do_issue  = 1'b0;
    tmo_hit   = 1'b0;
    gap_done  = 1'b0;
    case (state)
      IDLE: if (enable && |pending) begin
        do_pick   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        do_issue  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = SEND;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = GAP;
        end
      end
      SEND: if (!tx_busy) state_nxt = GAP;
      GAP: if (gap_cnt == GAP_W'(1)) begin
        gap_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    gap_load = (state_nxt == GAP) && (state != GAP);
  end

  // tx_start/ack are registered, so they land one cycle after grant
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_word  <= '0;
      grant    <= '0;
      ack      <= '0;
      pending  <= '0;
      err_tmo  <= 1'b0;
      last     <= 3'(N_REQ - 1);
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      tx_start <= do_issue;
      err_tmo  <= tmo_hit;
      ack      <= do_issue ? grant : '0;
      pending  <= (pending & ~(do_issue ? grant : '0)) | rise;
      if (do_pick) begin
        for (int i = 0; i < N_REQ; i++) grant[i] <= (int'(sel) == i);
        tx_word <= words[sel];
        last    <= pick;
      end else if (gap_done) begin
        grant <= '0;
      end
      if (do_issue)                tmo_cnt <= '0;
      else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
      if (gap_load)                gap_cnt <= GAP_LOAD;
      else if (state == GAP)       gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_arinc429_tx_sched.sv
// tb/tb_arinc429_tx_sched.sv - directed self-checking bench for arinc429_tx_sched
module tb_arinc429_tx_sched;

  localparam int N_REQ    = 4;
  localparam int BIT_CLKS = 10;
  localparam int GAP_BITS = 4;
  localparam int BUSY_TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [3:0]   req;
  logic [127:0] word_in;
  logic         tx_busy = 1'b0;
  logic         tx_start;
  logic [31:0]  tx_word;
  logic [3:0]   grant, ack, pending;
  logic         err_tmo;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ack_cnt [4] = '{default: 0};
  int busy_left = 0;
  logic model_on;
  int busy_len;

  logic [31:0] exp_word [4];
  int order [5] = '{0, 1, 2, 3, 0};
  int n, base;

  arinc429_tx_sched #(
    .N_REQ(N_REQ), .BIT_CLKS(BIT_CLKS), .GAP_BITS(GAP_BITS), .BUSY_TMO(BUSY_TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .word_in(word_in),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_word(tx_word), .grant(grant),
    .ack(ack), .pending(pending), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  // Transmitter: busy from the cycle tx_start is seen, for busy_len cycles
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      tx_busy = 1'b0;
      busy_left = 0;
    end else if (model_on && tx_start === 1'b1) begin
      tx_busy = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 1) begin
      busy_left--;
    end else begin
      tx_busy = 1'b0;
      busy_left = 0;
    end
  end

  always @(negedge clk) begin
    if (tx_start === 1'b1) start_cnt++;
    for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input int bound);
    int k = 0;
    while (tx_start !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    chk(tag, tx_start, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while ((grant !== 4'b0 || tx_busy !== 1'b0) && k < bound) begin
      step();
      k++;
    end
    chk(tag, grant, 0);
  endtask

  initial begin
    exp_word[0] = 32'h1111_0100;
    exp_word[1] = 32'h2222_0201;
    exp_word[2] = 32'hA5A5_0301;
    exp_word[3] = 32'h4444_0401;
    word_in  = {exp_word[3], exp_word[2], exp_word[1], exp_word[0]};
    rst      = 1'b1;
    enable   = 1'b1;
    req      = 4'b0;
    model_on = 1'b1;
    busy_len = 320;

    step();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_word", tx_word, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err_tmo", err_tmo, 0);
    rst = 1'b0;
    step();

    // Single request from source 2
    req = 4'b0100;
    step();
    chk("single_pending", pending, 4'b0100);
    chk("single_grant_early", grant, 0);
    step();
    chk("single_grant", grant, 4'b0100);
    chk("single_no_start_yet", tx_start, 0);
    chk("single_word", tx_word, 32'hA5A5_0301);
    step();
    chk("single_start", tx_start, 1);
    chk("single_ack", ack, 4'b0100);
    chk("single_pending_clr", pending, 0);
    step();
    chk("single_start_pulse", tx_start, 0);
    chk("single_ack_pulse", ack, 0);
    req = 4'b0010;
    n = 0;
    while (tx_busy === 1'b1 && n < 1000) begin step(); n++; end
    chk("single_busy_fall", tx_busy, 0);
    n = 0;
    while (tx_start !== 1'b1 && n < 1000) begin step(); n++; end
    chk("gap_spacing", (n >= 42 && n <= 43), 1);
    chk("gap_next_grant", grant, 4'b0010);
    chk("gap_next_word", tx_word, 32'h2222_0201);
    req = 4'b0;
    busy_len = 20;
    wait_idle("single_idle", 1000);

    // Round robin from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    req = 4'b0;
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("rr_start_%0d", k), 300);
      chk($sformatf("rr_grant_%0d", k), grant, 32'(1) << order[k]);
      chk($sformatf("rr_word_%0d", k), tx_word, exp_word[order[k]]);
      step();
      if (k == 2) begin
        step();
        req = 4'b1001;
        step();
        req = 4'b0;
      end
    end
    wait_idle("rr_idle", 300);

    // Held level gives exactly one request
    base = ack_cnt[1];
    req[1] = 1'b1;
    repeat (2000) step();
    chk("held_one_ack", ack_cnt[1] - base, 1);
    req[1] = 1'b0;
    step();
    req[1] = 1'b1;
    wait_start("held_restart", 200);
    step();
    wait_idle("held_idle", 300);
    chk("held_two_acks", ack_cnt[1] - base, 2);
    req[1] = 1'b0;
    step();

    // Rise in the ISSUE cycle keeps the request pending
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    step();
    chk("setclr_grant", grant, 4'b0010);
    chk("setclr_in_issue", tx_start, 0);
    req[1] = 1'b1;
    step();
    chk("setclr_ack", ack, 4'b0010);
    chk("setclr_pending", pending, 4'b0010);
    req[1] = 1'b0;
    step();
    wait_start("setclr_resend", 300);
    chk("setclr_resend_grant", grant, 4'b0010);
    step();
    wait_idle("setclr_idle", 300);

    // Busy timeout
    model_on = 1'b0;
    req = 4'b0001;
    step();
    req = 4'b0;
    wait_start("tmo_start", 20);
    n = 0;
    while (err_tmo !== 1'b1 && n < 50) begin step(); n++; end
    chk("tmo_delay", n, BUSY_TMO);
    step();
    chk("tmo_pulse", err_tmo, 0);
    chk("tmo_grant_gap", grant, 4'b0001);
    wait_idle("tmo_idle", 100);

    // enable=0 holds requests in pending
    enable = 1'b0;
    base = start_cnt;
    req = 4'b0011;
    step();
    req = 4'b0;
    repeat (10) step();
    chk("en_pending", pending, 4'b0011);
    chk("en_no_start", start_cnt - base, 0);
    chk("en_no_grant", grant, 0);
    enable = 1'b1;
    n = 0;
    while (tx_start !== 1'b1 && n < 5) begin step(); n++; end
    chk("en_start_fast", (tx_start === 1'b1 && n <= 2), 1);
    chk("en_rr_grant", grant, 4'b0010);
    model_on = 1'b1;
    step();
    wait_idle("en_idle", 200);

    // Reset during SEND
    wait_start("rst_mid_start", 20);
    chk("rst_mid_grant", grant, 4'b0001);
    repeat (5) step();
    req = 4'b0100;
    step();
    req = 4'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_grant0", grant, 0);
    chk("rst_mid_pending0", pending, 0);
    chk("rst_mid_start0", tx_start, 0);
    chk("rst_mid_word0", tx_word, 0);
    chk("rst_mid_ack0", ack, 0);
    chk("rst_mid_err0", err_tmo, 0);
    base = start_cnt;
    repeat (100) step();
    chk("rst_mid_quiet", start_cnt - base, 0);
    req = 4'b1000;
    step();
    req = 4'b0;
    wait_start("rst_mid_new", 20);
    chk("rst_mid_new_grant", grant, 4'b1000);
    chk("rst_mid_new_word", tx_word, 32'h4444_0401);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
